// File: rtl/rr_arbiter_client.sv
// rtl/rr_arbiter_client.sv - client side of the rr_arbiter request/grant/ack handshake
// Optional grant protocol checker: define RR_CLIENT_GRANT_CHECK_EN.
module rr_arbiter_client #(
  parameter int WIDTH     = 4,
  parameter int CNT_W     = 3,
  parameter int BURST_LEN = 4
) (
  input  logic                     clk,
  input  logic                     resetb,
  input  logic [WIDTH-1:0]         job_push,
  input  logic [WIDTH-1:0]         grant,
  output logic [WIDTH-1:0]         request,
  output logic                     ack,
  output logic                     beat_valid,
  output logic [$clog2(WIDTH)-1:0] beat_id,
  output logic                     beat_last,
  output logic [WIDTH-1:0]         overflow,
  output logic                     proto_err
);

  localparam int IW = $clog2(WIDTH);
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0]    BEAT_LAST = BW'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] PEND_MAX  = '1;

  typedef enum logic [1:0] {IDLE, XFER, ACK, RELEASE} state_t;

  state_t           state, state_nxt;
  logic [IW-1:0]    id, id_nxt;
  logic [BW-1:0]    beat, beat_nxt;
  logic [CNT_W-1:0] pend [WIDTH];
  logic [WIDTH-1:0] dec;
  logic [IW-1:0]    gidx;
  logic             grant_onehot;
  logic             take;

  always_comb begin
    gidx = '0;
    for (int i = 0; i < WIDTH; i++)
      if (grant[i]) gidx = IW'(i);
  end

  assign grant_onehot = (grant != '0) && ((grant & (grant - WIDTH'(1))) == '0);
  assign take         = (state == IDLE) && grant_onehot && ((grant & request) != '0);

  // The finishing channel stays masked through ACK and RELEASE so the arbiter can move on.
  always_comb begin
    request = '0;
    dec     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      request[i] = (pend[i] != '0) &&
                   !((id == IW'(i)) && ((state == ACK) || (state == RELEASE)));
      dec[i]     = (state == ACK) && (id == IW'(i));
    end
  end

  always_comb begin
    state_nxt = state;
    id_nxt    = id;
    beat_nxt  = beat;
    case (state)
      IDLE: begin
        if (take) begin
          id_nxt    = gidx;
          beat_nxt  = '0;
          state_nxt = XFER;
        end
      end
      XFER: begin
        beat_nxt = beat + BW'(1);
        if (beat == BEAT_LAST) state_nxt = ACK;
      end
      ACK:     state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign beat_valid = (state == XFER);
  assign beat_last  = (state == XFER) && (beat == BEAT_LAST);
  assign ack        = (state == ACK);
  assign beat_id    = id;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state <= IDLE;
      id    <= '0;
      beat  <= '0;
    end else begin
      state <= state_nxt;
      id    <= id_nxt;
      beat  <= beat_nxt;
    end
  end

  // A push coinciding with its own channel's completion cancels out.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      overflow <= '0;
      for (int i = 0; i < WIDTH; i++) pend[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        overflow[i] <= 1'b0;
        if (job_push[i] && !dec[i]) begin
          if (pend[i] == PEND_MAX) overflow[i] <= 1'b1;
          else                     pend[i]     <= pend[i] + CNT_W'(1);
        end else if (dec[i] && !job_push[i] && (pend[i] != '0)) begin
          pend[i] <= pend[i] - CNT_W'(1);
        end
      end
    end
  end

`ifdef RR_CLIENT_GRANT_CHECK_EN
  logic bad_grant;

  assign bad_grant = ((state == IDLE) && (grant != '0) &&
                      (!grant_onehot || ((grant & ~request) != '0))) ||
                     ((state == XFER) && !grant[id]);

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) proto_err <= 1'b0;
    else         proto_err <= proto_err | bad_grant;
  end
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter_client.sv
// tb/tb_rr_arbiter_client.sv - self-checking bench for rr_arbiter_client
module tb_rr_arbiter_client;
  localparam int WIDTH = 4;
  localparam int CNT_W = 3;
  localparam int BURST = 4;

  logic             clk = 1'b0;
  logic             resetb;
  logic [WIDTH-1:0] job_push;
  logic [WIDTH-1:0] grant;
  logic [WIDTH-1:0] request;
  logic             ack;
  logic             beat_valid;
  logic [1:0]       beat_id;
  logic             beat_last;
  logic [WIDTH-1:0] overflow;
  logic             proto_err;

  rr_arbiter_client #(.WIDTH(WIDTH), .CNT_W(CNT_W), .BURST_LEN(BURST)) dut (
    .clk(clk), .resetb(resetb), .job_push(job_push), .grant(grant),
    .request(request), .ack(ack), .beat_valid(beat_valid), .beat_id(beat_id),
    .beat_last(beat_last), .overflow(overflow), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_acks   = 0;
  int cur_beats = 0;
  int cur_id    = 0;
  int sb[$];

  typedef struct {
    logic [WIDTH-1:0] push;
    int               ch;
    logic [WIDTH-1:0] req_after_push;
    logic [WIDTH-1:0] req_after_done;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Burst monitor: every ack retires one expected channel from the scoreboard.
  always @(negedge clk) begin
    if (!resetb) begin
      cur_beats = 0;
    end else begin
      if (beat_valid) begin
        if (cur_beats == 0) cur_id = int'(beat_id);
        else chk("beat_id_stable", 32'(beat_id), 32'(cur_id));
        cur_beats++;
        chk("beat_last", 32'(beat_last), 32'(cur_beats == BURST));
      end
      if (ack) begin
        n_acks++;
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_ack: got ack with empty scoreboard, required none");
        end else begin
          chk("burst_id", 32'(cur_id), 32'(sb.pop_front()));
          chk("burst_beats", 32'(cur_beats), 32'(BURST));
        end
        cur_beats = 0;
      end
    end
  end

  task automatic push_once(input logic [WIDTH-1:0] v);
    job_push = v;
    tick();
    job_push = '0;
  endtask

  task automatic run_grant(input int ch, input logic [WIDTH-1:0] ack_push,
                           input logic [WIDTH-1:0] exp_req);
    bit got_ack;
    got_ack = 1'b0;
    grant = WIDTH'(1) << ch;
    sb.push_back(ch);
    tick();
    chk("first_beat_valid", 32'(beat_valid), 32'd1);
    chk("first_beat_id", 32'(beat_id), 32'(ch));
    for (int k = 0; k < 20; k++) begin
      tick();
      if (ack) begin
        got_ack = 1'b1;
        break;
      end
    end
    if (!got_ack) begin
      n_checks++;
      n_errors++;
      $display("FAIL ack_timeout: got no ack on ch %0d within 20 cycles, required one", ch);
    end
    grant = '0;
    chk("req_masked_ack", 32'(request[ch]), 32'd0);
    job_push = ack_push;
    tick();
    job_push = '0;
    chk("ack_one_cycle", 32'(ack), 32'd0);
    chk("req_masked_release", 32'(request[ch]), 32'd0);
    tick();
    chk("req_after_burst", 32'(request), 32'(exp_req));
  endtask

  vec_t vecs[4];

  initial begin
    int acks0;
    vecs[0] = '{push: 4'b0010, ch: 1, req_after_push: 4'b0010, req_after_done: 4'b0000};
    vecs[1] = '{push: 4'b0001, ch: 0, req_after_push: 4'b0001, req_after_done: 4'b0000};
    vecs[2] = '{push: 4'b0100, ch: 2, req_after_push: 4'b0100, req_after_done: 4'b0000};
    vecs[3] = '{push: 4'b1000, ch: 3, req_after_push: 4'b1000, req_after_done: 4'b0000};

    resetb   = 1'b0;
    job_push = '0;
    grant    = '0;
    for (int k = 0; k < 10; k++) begin
      job_push = WIDTH'($urandom_range(1, 15));
      tick();
      chk("reset_request", 32'(request), 32'd0);
      chk("reset_beat_valid", 32'(beat_valid | ack | (|overflow)), 32'd0);
    end
    job_push = '0;
    resetb   = 1'b1;
    tick();
    chk("post_reset_request", 32'(request), 32'd0);
    chk("post_reset_beat_id", 32'(beat_id), 32'd0);

    for (int v = 0; v < 4; v++) begin
      push_once(vecs[v].push);
      chk("req_after_push", 32'(request), 32'(vecs[v].req_after_push));
      run_grant(vecs[v].ch, '0, vecs[v].req_after_done);
    end

    acks0 = n_acks;
    push_once(4'b1010);
    push_once(4'b1010);
    chk("req_two_channels", 32'(request), 32'b1010);
    run_grant(1, '0, 4'b1010);
    run_grant(3, '0, 4'b1010);
    run_grant(1, '0, 4'b1000);
    run_grant(3, '0, 4'b0000);
    chk("alt_ack_count", 32'(n_acks - acks0), 32'd4);

    for (int k = 0; k < 8; k++) begin
      job_push = 4'b0001;
      tick();
      chk("overflow_pulse", 32'(overflow), (k == 7) ? 32'b0001 : 32'd0);
    end
    job_push = '0;
    tick();
    chk("overflow_clears", 32'(overflow), 32'd0);
    acks0 = n_acks;
    for (int k = 0; k < 7; k++)
      run_grant(0, '0, (k < 6) ? 4'b0001 : 4'b0000);
    chk("full_queue_acks", 32'(n_acks - acks0), 32'd7);

    push_once(4'b0100);
    run_grant(2, 4'b0100, 4'b0100);
    run_grant(2, '0, 4'b0000);

    push_once(4'b0001);
    grant = 4'b0001;
    tick();
    tick();
    tick();
    chk("beat2_valid", 32'(beat_valid), 32'd1);
    acks0  = n_acks;
    resetb = 1'b0;
    grant  = '0;
    #1;
    chk("abort_beat_valid", 32'(beat_valid), 32'd0);
    chk("abort_ack", 32'(ack), 32'd0);
    chk("abort_request", 32'(request), 32'd0);
    tick();
    tick();
    resetb = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    chk("abort_no_ack", 32'(n_acks - acks0), 32'd0);
    chk("abort_request_after", 32'(request), 32'd0);

    grant = 4'b0110;
    tick();
    grant = '0;
    tick();
    chk("illegal_grant_ignored", 32'(beat_valid), 32'd0);
`ifdef RR_CLIENT_GRANT_CHECK_EN
    chk("proto_err_set", 32'(proto_err), 32'd1);
    tick();
    chk("proto_err_sticky", 32'(proto_err), 32'd1);
`else
    chk("proto_err_tied", 32'(proto_err), 32'd0);
`endif
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
